sprite_linebuf: RTL

Ping-pong sprite line buffer placed between the sprite engine and the video mixer.
- The sprite engine writes pixels for the next scanline into the back bank through a valid/ready handshake. The first opaque pixel written to a location wins.
- The mixer reads the front bank at the current horizontal position. Each location is cleared to transparent immediately after it is read.
- Storage is one 2*2^AW x DW true dual-port RAM. The bank bit is the RAM address MSB.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/dpram.sv | 33 +++
 rtl/sprite_linebuf.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite line buffer.
//   AW_DEF    - default pixel X width (each bank holds 2^AW_DEF entries)
//   DW_DEF    - default pixel (palette index) width
//   TRANS_DEF - default transparent / clear value
//   wr_state_e - write FSM state encoding (INIT sweep, IDLE, RD, CMP)
package sprite_pkg;

  localparam int          AW_DEF    = 9;
  localparam int          DW_DEF    = 8;
  localparam logic [7:0]  TRANS_DEF = 8'h0F;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    CMP  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/dpram.sv
// dpram: generic true dual-port RAM, single clock, registered reads.
//   clk                  - clock for both ports
//   we_a/addr_a/din_a    - port A write enable, address, write data
//   q_a                  - port A registered read data (read-first)
//   we_b/addr_b/din_b    - port B write enable, address, write data
//   q_b                  - port B registered read data (read-first)
// When both ports write the same address in one cycle, port B wins.
module dpram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] q_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    // Port B is written last so its clear overrides a same-address port A write.
    if (we_b) mem[addr_b] <= din_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/sprite_linebuf.sv
// sprite_linebuf: ping-pong sprite line buffer between sprite engine and mixer.
//   CLK    - single clock
//   RESET  - synchronous active-high reset; restarts the clear sweep
//   LSTART - line start pulse, swaps front/back banks (ignored during INIT)
//   WVALID/WREADY/WX/WD - sprite pixel write into the back bank; first opaque
//            pixel written to a location wins, transparent pixels are dropped
//   PCE/HPOS - readout request for the front bank at HPOS (not on consecutive cycles)
//   DOUT   - front-bank pixel, valid 2 cycles after PCE, held until next read
//   BUSY   - initial clear sweep in progress
// RAM port A: INIT sweep and read-modify-write of sprite pixels.
// RAM port B: readout followed by clear-after-read.
module sprite_linebuf
  import sprite_pkg::*;
#(
  parameter int          AW    = AW_DEF,
  parameter int          DW    = DW_DEF,
  parameter logic [DW-1:0] TRANS = DW'(TRANS_DEF)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LSTART,
  input  logic          WVALID,
  output logic          WREADY,
  input  logic [AW-1:0] WX,
  input  logic [DW-1:0] WD,
  input  logic          PCE,
  input  logic [AW-1:0] HPOS,
  output logic [DW-1:0] DOUT,
  output logic          BUSY
);

  wr_state_e     state_reg;
  logic          bank_reg;
  logic [AW:0]   cnt_reg;
  logic [AW:0]   wr_addr_reg;
  logic [DW-1:0] wr_data_reg;
  logic          wready_reg;
  logic          busy_reg;

  logic          rd_pend_reg;
  logic [AW:0]   rd_addr_reg;
  logic [DW-1:0] dout_reg;
  logic          rd_accept;

  logic          ram_we_a;
  logic [AW:0]   ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_q_a;
  logic          ram_we_b;
  logic [AW:0]   ram_addr_b;
  logic [DW-1:0] ram_din_b;
  logic [DW-1:0] ram_q_b;

  assign WREADY = wready_reg;
  assign BUSY   = busy_reg;
  assign DOUT   = dout_reg;

  // Port A: sweep address during INIT, otherwise the latched write target.
  // In CMP the registered read of the RD cycle decides whether we may write.
  always_comb begin
    ram_we_a   = 1'b0;
    ram_addr_a = wr_addr_reg;
    ram_din_a  = wr_data_reg;
    case (state_reg)
      INIT: begin
        ram_we_a   = 1'b1;
        ram_addr_a = cnt_reg;
        ram_din_a  = TRANS;
      end
      CMP:     ram_we_a = (ram_q_a == TRANS);
      default: ram_we_a = 1'b0;
    endcase
  end

  // Port B: a read is only taken when the previous cycle was not a read,
  // because the cycle after a read is spent clearing that location.
  assign rd_accept  = PCE && !busy_reg && !rd_pend_reg;
  assign ram_we_b   = rd_pend_reg;
  assign ram_addr_b = rd_pend_reg ? rd_addr_reg : {~bank_reg, HPOS};
  assign ram_din_b  = TRANS;

  // Write FSM with registered WREADY/BUSY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= INIT;
      cnt_reg     <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= TRANS;
      wready_reg  <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == '1) begin
            state_reg  <= IDLE;
            wready_reg <= 1'b1;
            busy_reg   <= 1'b0;
          end
        end
        IDLE: begin
          // Transparent requests are consumed here without touching the RAM.
          if (WVALID && (WD != TRANS)) begin
            wr_addr_reg <= {bank_reg, WX};
            wr_data_reg <= WD;
            wready_reg  <= 1'b0;
            state_reg   <= RD;
          end
        end
        RD: state_reg <= CMP;
        CMP: begin
          state_reg  <= IDLE;
          wready_reg <= 1'b1;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  // Bank control and readout pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bank_reg    <= 1'b0;
      rd_pend_reg <= 1'b0;
      rd_addr_reg <= '0;
      dout_reg    <= TRANS;
    end else begin
      if (LSTART && (state_reg != INIT)) bank_reg <= ~bank_reg;
      rd_pend_reg <= rd_accept;
      // Latching the address keeps the clear on the location actually read,
      // even when the bank swaps in between.
      if (rd_accept) rd_addr_reg <= {~bank_reg, HPOS};
      if (rd_pend_reg) dout_reg <= ram_q_b;
    end
  end

  dpram #(
    .AW (AW + 1),
    .DW (DW)
  ) u_ram (
    .clk    (CLK),
    .we_a   (ram_we_a),
    .addr_a (ram_addr_a),
    .din_a  (ram_din_a),
    .q_a    (ram_q_a),
    .we_b   (ram_we_b),
    .addr_b (ram_addr_b),
    .din_b  (ram_din_b),
    .q_b    (ram_q_b)
  );

endmodule
